// File: rtl/wire_key_pkg.sv
// Shared types and sizing for the wire-obfuscation key loader.
package wire_key_pkg;

    localparam int unsigned KEY_W   = 12;
    localparam int unsigned NUM_SEL = KEY_W / 2;
    localparam int unsigned BEATS   = NUM_SEL + 1;

    // Beat counter width for a given key width: key beats plus one parity beat.
    function automatic int unsigned beat_cnt_w(input int unsigned key_w);
        return $clog2(key_w / 2 + 1);
    endfunction

    localparam int unsigned BEAT_W = beat_cnt_w(KEY_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RETRY,
        ST_CHECK,
        ST_DONE,
        ST_FAIL
    } state_t;

endpackage

// File: rtl/wire_key_beat_timer.sv
// Per-beat ack timeout counter: cleared on demand, counts while enabled,
// flags when it has waited TIMEOUT-1 cycles.
module wire_key_beat_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o = (cnt_q == TC_VAL);

    // Next count: clear wins, then count up and park at terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wire_key_loader.sv
// Loads the wire-obfuscation key from the key store beat by beat into a
// shadow register, checks parity, and commits it to the core atomically.
module wire_key_loader #(
    parameter int unsigned KEY_W     = wire_key_pkg::KEY_W,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ks_req,
    input  logic             ks_ack,
    input  logic [1:0]       ks_data,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             busy,
    output logic             err
);

    import wire_key_pkg::*;

    localparam int unsigned SEL_N  = KEY_W / 2;
    localparam int unsigned BCNT_W = beat_cnt_w(KEY_W);
    localparam int unsigned RCNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [BCNT_W-1:0] PAR_BEAT  = BCNT_W'(SEL_N);
    localparam logic [RCNT_W-1:0] RETRY_MAX = RCNT_W'(MAX_RETRY);

    state_t             state_q, state_d;
    logic [BCNT_W-1:0]  beat_q, beat_d;
    logic [KEY_W-1:0]   shadow_q, shadow_d;
    logic               par_q, par_d;
    logic [RCNT_W-1:0]  retry_q, retry_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               kv_q, kv_d;
    logic               err_q, err_d;

    logic               xfer;
    logic               timer_tc;

    assign xfer      = (state_q == ST_REQ) && ks_ack;
    assign ks_req    = (state_q == ST_REQ);
    assign busy      = (state_q == ST_REQ) || (state_q == ST_RETRY) || (state_q == ST_CHECK);
    assign key       = key_q;
    assign key_valid = kv_q;
    assign err       = err_q;

    // Timer only runs in REQ; leaving REQ holds it cleared, so every REQ
    // entry starts from zero without a separate entry pulse.
    wire_key_beat_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i ((state_q != ST_REQ) || xfer),
        .en_i  (state_q == ST_REQ),
        .tc_o  (timer_tc)
    );

    // Next-state, beat capture, parity check, commit and retry accounting.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        shadow_d = shadow_q;
        par_d    = par_q;
        retry_d  = retry_q;
        key_d    = key_q;
        kv_d     = kv_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_d  = ST_REQ;
                    beat_d   = '0;
                    shadow_d = '0;
                    par_d    = 1'b0;
                    retry_d  = '0;
                    key_d    = '0;
                    kv_d     = 1'b0;
                    err_d    = 1'b0;
                end
            end

            ST_REQ: begin
                if (xfer) begin
                    if (beat_q == PAR_BEAT) begin
                        par_d   = ks_data[0];
                        state_d = ST_CHECK;
                    end else begin
                        for (int unsigned i = 0; i < SEL_N; i++) begin
                            if (beat_q == BCNT_W'(i)) begin
                                shadow_d[2*i +: 2] = ks_data;
                            end
                        end
                        beat_d = beat_q + 1'b1;
                    end
                end else if (timer_tc) begin
                    state_d = ST_RETRY;
                end
            end

            ST_CHECK: begin
                if ((^shadow_q) == par_q) begin
                    key_d   = shadow_q;
                    kv_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RETRY;
                end
            end

            ST_RETRY: begin
                beat_d   = '0;
                shadow_d = '0;
                if (retry_q == RETRY_MAX) begin
                    state_d = ST_FAIL;
                    err_d   = 1'b1;
                    key_d   = '0;
                    kv_d    = 1'b0;
                end else begin
                    retry_d = retry_q + 1'b1;
                    state_d = ST_REQ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            shadow_q <= '0;
            par_q    <= 1'b0;
            retry_q  <= '0;
            key_q    <= '0;
            kv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            shadow_q <= shadow_d;
            par_q    <= par_d;
            retry_q  <= retry_d;
            key_q    <= key_d;
            kv_q     <= kv_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_wire_key_loader.sv
// Directed bench for wire_key_loader: cycle table plus multi-cycle sequences.
module tb_wire_key_loader;

    localparam int unsigned KEY_W     = 12;
    localparam int unsigned TIMEOUT   = 16;
    localparam int unsigned MAX_RETRY = 3;

    // 12'h36B has seven ones -> even-parity bit 1; 12'hA5C has six -> 0.
    localparam logic [11:0] K1 = 12'h36B;
    localparam logic        P1 = 1'b1;
    localparam logic [11:0] K2 = 12'hA5C;
    localparam logic        P2 = 1'b0;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             ks_req;
    logic             ks_ack;
    logic [1:0]       ks_data;
    logic [KEY_W-1:0] key;
    logic             key_valid;
    logic             busy;
    logic             err;

    int n_total = 0;
    int n_bad   = 0;

    wire_key_loader #(
        .KEY_W     (KEY_W),
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ks_req    (ks_req),
        .ks_ack    (ks_ack),
        .ks_data   (ks_data),
        .key       (key),
        .key_valid (key_valid),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    typedef struct {
        logic       rst_n;
        logic       start;
        logic       ack;
        logic [1:0] data;
        logic [15:0] exp;   // {ks_req, busy, key_valid, err, key}
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic a, input logic [1:0] d,
                       input logic rq, input logic bz, input logic kv, input logic er,
                       input logic [11:0] k);
        vec_t v;
        v.rst_n = r; v.start = s; v.ack = a; v.data = d;
        v.exp   = {rq, bz, kv, er, k};
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, expv);
        end
    endtask

    function automatic logic [1:0] beat_of(input logic [11:0] k, input int i, input logic p);
        logic [1:0] r;
        if (i < 6) r = k[2*i +: 2];
        else       r = {1'b0, p};
        return r;
    endfunction

    task automatic beat(input logic [11:0] k, input int i, input logic p);
        ks_ack  = 1'b1;
        ks_data = beat_of(k, i, p);
        tick();
        ks_ack  = 1'b0;
        ks_data = 2'b00;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // start, seven back-to-back beats, CHECK, commit at start edge + 8.
    task automatic full_load(input string nm, input logic [11:0] k, input logic p);
        pulse_start();
        chk({nm, "_req_at_T"}, ks_req, 1);
        for (int i = 0; i < 7; i++) beat(k, i, p);
        chk({nm, "_kv_at_T7"}, {busy, key_valid, key}, {1'b1, 1'b0, 12'h000});
        tick();
        chk({nm, "_commit_T8"}, {ks_req, busy, key_valid, err, key}, {4'b0010, k});
    endtask

    initial begin
        int hi;
        rst_n = 1'b0; start = 1'b0; ks_ack = 1'b0; ks_data = 2'b00;

        // Reset beats everything, then nominal load of K1, reload of K2.
        add(0, 1, 1, 2'b11, 0, 0, 0, 0, 12'h000);
        add(0, 1, 1, 2'b11, 0, 0, 0, 0, 12'h000);
        add(1, 1, 0, 2'b00, 1, 1, 0, 0, 12'h000);
        for (int i = 0; i < 6; i++)
            add(1, 0, 1, beat_of(K1, i, P1), 1, 1, 0, 0, 12'h000);
        add(1, 0, 1, {1'b1, P1}, 0, 1, 0, 0, 12'h000);
        add(1, 0, 1, 2'b10,      0, 0, 1, 0, K1);
        add(1, 0, 1, 2'b00,      0, 0, 1, 0, K1);
        add(1, 1, 0, 2'b00,      1, 1, 0, 0, 12'h000);
        for (int i = 0; i < 6; i++)
            add(1, 1, 1, beat_of(K2, i, P2), 1, 1, 0, 0, 12'h000);
        add(1, 0, 1, {1'b0, P2}, 0, 1, 0, 0, 12'h000);
        add(1, 0, 0, 2'b00,      0, 0, 1, 0, K2);

        for (int n = 0; n < vecs.size(); n++) begin
            rst_n   = vecs[n].rst_n;
            start   = vecs[n].start;
            ks_ack  = vecs[n].ack;
            ks_data = vecs[n].data;
            tick();
            chk($sformatf("vec%0d", n), {ks_req, busy, key_valid, err, key}, vecs[n].exp);
        end
        start = 1'b0; ks_ack = 1'b0; ks_data = 2'b00;

        // Bad parity first attempt, then a clean retry.
        pulse_start();
        for (int i = 0; i < 7; i++) beat(K1, i, ~P1);
        chk("perr_check", {ks_req, busy}, 2'b01);
        tick();
        chk("perr_retry", {ks_req, busy, key_valid}, 3'b010);
        tick();
        chk("perr_req_again", ks_req, 1);
        chk("perr_retry_cnt", 32'(dut.retry_q), 1);
        for (int i = 0; i < 7; i++) beat(K1, i, P1);
        tick();
        chk("perr_commit", {key_valid, err, key}, {2'b10, K1});

        // No ack at all: four full REQ windows, then sticky failure.
        pulse_start();
        chk("to_start_clears", {key_valid, key}, 13'h0000);
        for (int a = 0; a < 4; a++) begin
            hi = 0;
            while (ks_req === 1'b1 && hi < 100) begin
                hi++;
                tick();
            end
            chk($sformatf("to_window%0d", a), hi, TIMEOUT);
            chk($sformatf("to_drop%0d", a), {ks_req, busy, err}, 3'b010);
            tick();
        end
        chk("to_fail", {ks_req, busy, key_valid, err, key}, {4'b0001, 12'h000});
        ks_ack = 1'b1;
        tick(); tick();
        ks_ack = 1'b0;
        chk("to_fail_held", {ks_req, busy, err}, 3'b001);

        // Start from FAIL clears err; ack stalled 10 cycles mid-load.
        pulse_start();
        chk("stall_err_clear", {ks_req, err}, 2'b10);
        for (int i = 0; i < 4; i++) beat(K2, i, P2);
        hi = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ks_req === 1'b1) hi++;
        end
        chk("stall_no_retry", hi, 10);
        for (int i = 4; i < 7; i++) beat(K2, i, P2);
        tick();
        chk("stall_commit", {key_valid, err, key}, {2'b10, K2});
        for (int c = 0; c < 3; c++) begin
            ks_ack = 1'b1; ks_data = 2'(c);
            tick();
        end
        ks_ack = 1'b0;
        chk("stall_ack_ignored", {ks_req, key_valid, key}, {2'b01, K2});

        // Reset after beat 3, then a clean load from beat 0.
        pulse_start();
        for (int i = 0; i < 4; i++) beat(K1, i, P1);
        rst_n = 1'b0; ks_ack = 1'b1;
        tick();
        chk("rst_mid", {ks_req, busy, key_valid, err, key}, 16'h0000);
        rst_n = 1'b1; ks_ack = 1'b0;
        tick();
        chk("rst_idle", {ks_req, busy}, 2'b00);
        full_load("rst_reload", K1, P1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
